// File: rtl/operand_debounce_pkg.sv
// Shared switch-debounce timing constants for switch-driven projects.
// The default CNT_MAX gives 10 ms at a 27 MHz system clock.
package operand_debounce_pkg;

    localparam int DEBOUNCE_CNT_MAX_DEFAULT = 270000;
    localparam int SYNC_DEPTH               = 2;

    // Counter width that can hold values 0..cnt_max. The result is never below 1.
    function automatic int cnt_width(input int cnt_max);
        int w;
        w = $clog2(cnt_max + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Debounces one active-low switch. The path is a synchronizer, then a stability
// counter, then a registered stable level.
module debounce_bit
    import operand_debounce_pkg::*;
#(
    parameter int CNT_MAX = DEBOUNCE_CNT_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_n,
    output logic stable,
    output logic cnt_nz
);

    localparam int              CW       = cnt_width(CNT_MAX);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CNT_MAX - 1);

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  stable_q, stable_d;
    logic                  level;

    assign level = sync_q[SYNC_DEPTH-1];

    // The counter reaches CNT_LAST and then accepts the new level on that edge.
    // Because of this, the counter never holds CNT_MAX and it cannot wrap.
    always_comb begin
        sync_d   = {sync_q[SYNC_DEPTH-2:0], sw_n};
        cnt_d    = '0;
        stable_d = stable_q;
        if (level != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = level;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '1;
            cnt_q    <= '0;
            stable_q <= 1'b1;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;
    assign cnt_nz = (cnt_q != '0);

endmodule

// File: rtl/operand_debounce.sv
// Debounces the adder operand switches. OUT is the registered, inverted stable
// level of each switch. CHANGED and BUSY are reductions across all bits.
module operand_debounce
    import operand_debounce_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int CNT_MAX = DEBOUNCE_CNT_MAX_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] SW_N,
    output logic [WIDTH-1:0] OUT,
    output logic             CHANGED,
    output logic             BUSY
);

    logic [WIDTH-1:0] stable_vec;
    logic [WIDTH-1:0] cnt_nz_vec;

    logic [WIDTH-1:0] out_q, out_d;
    logic             changed_q, changed_d;
    logic             busy_q, busy_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .CNT_MAX (CNT_MAX)
        ) u_bit (
            .clk    (CLK),
            .rst    (RST),
            .sw_n   (SW_N[i]),
            .stable (stable_vec[i]),
            .cnt_nz (cnt_nz_vec[i])
        );
    end

    // CHANGED is registered next to OUT, so it rises in the same cycle that OUT shows the new value.
    always_comb begin
        out_d     = ~stable_vec;
        changed_d = (out_d != out_q);
        busy_d    = |cnt_nz_vec;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q     <= '0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            out_q     <= out_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
        end
    end

    assign OUT     = out_q;
    assign CHANGED = changed_q;
    assign BUSY    = busy_q;

endmodule
